cipher_round_ctrl: RTL and testbench
====================================

CIPHER_ROUND_CTRL -- requirements
Module: cipher_round_ctrl

Interface
REQ-001 SHALL have parameter ROUNDS, default 24, meaning the number of round iterations per block (legal 1..63).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  a plaintext block and key are offered.
REQ-005 SHALL have port in_ready  output  1  the block can accept a new block; high only in IDLE.
REQ-006 SHALL have port din  input  64  plaintext: rows 0..3 = din[63:48], [47:32], [31:16], [15:0].
REQ-007 SHALL have port key  input  128  master key, sampled together with din.
REQ-008 SHALL have port out_valid  output  1  dout holds a finished block.
REQ-009 SHALL have port out_ready  input  1  the consumer accepts dout.
REQ-010 SHALL have port dout  output  64  result block, same row packing as din.
REQ-011 SHALL have port busy  output  1  high in LOAD and RUN.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, RUN and DONE.
REQ-013 SHALL transition IDLE->LOAD when in_valid and in_ready are both high, latching din and key.
REQ-014 SHALL, in LOAD, clear the round counter to 0 and take rk = key_reg[127:96], then move to RUN.
REQ-015 SHALL, each RUN cycle, compute state' = substitution layer(state, rk); then row0 ^= rk[31:16] and row1 ^= rk[15:0]; then rotate row1 left by 1, row2 left by 8 and row3 left by 12.
REQ-016 SHALL, each RUN cycle, rotate key_reg left by 32 and XOR the 6-bit round counter into key_reg[5:0]; the next rk = key_reg[127:96].
REQ-017 SHALL move RUN->DONE in the cycle the counter equals ROUNDS-1, so exactly ROUNDS round updates occur.
REQ-018 SHALL hold out_valid high with dout stable in DONE until out_ready is high, then return to IDLE.
REQ-019 SHALL give a latency of ROUNDS+2 cycles from the accepting edge to out_valid, with no bubble.
REQ-020 SHALL ignore in_valid outside IDLE, with no latching and no state disturbance.
REQ-021 SHALL permit in_valid and the out_ready-driven DONE->IDLE transition in the same cycle, but SHALL accept a new block no earlier than the following cycle.
REQ-022 SHALL drive dout as zero whenever out_valid is low.

Reset
REQ-023 SHALL, on rst asserted at any time, including mid-RUN, force IDLE, clear state, key_reg and the counter, and discard any partial block.
REQ-024 SHALL drive these values during reset: in_ready=1, out_valid=0, busy=0, dout=0.

Configuration
REQ-025 SHALL, when macro CIPHER_ROUND_ABORT_EN is defined, add an input port abort (1 bit); abort high in LOAD or RUN SHALL return the FSM to IDLE on the next edge without asserting out_valid, and SHALL be ignored in IDLE and DONE.
REQ-026 SHALL, without CIPHER_ROUND_ABORT_EN, have no abort port and no abort logic.

Structure
REQ-027 SHALL place the FSM state enum, the row width constant (16) and the round-counter width (6) in the shared package cipher_pkg.
REQ-028 SHALL isolate the combinational round function of REQ-015 in one sub-module, cipher_round, which contains the team's substitution layer; the FSM, counter and key register SHALL remain in cipher_round_ctrl.

Verification
REQ-029 SHALL cover ROUNDS=24 with din=0 and key=0, out_ready=1: in_valid accepted at cycle 0, busy high cycles 1-25, out_valid at cycle 26, and dout equal to the C reference model.
REQ-030 SHALL cover back-pressure with out_ready held low for 10 cycles after out_valid: dout stable, in_ready=0, and a second in_valid ignored throughout.
REQ-031 SHALL cover rst pulsed at RUN round 7: the next cycle shows in_ready=1, out_valid=0 and dout=0, and a fresh block then completes correctly.
REQ-032 SHALL cover ROUNDS=1 with din=64'h0123456789ABCDEF and key=128'h0F0E..00: out_valid three cycles after acceptance, matching the model.
REQ-033 SHALL cover, with CIPHER_ROUND_ABORT_EN defined, abort at RUN round 3: IDLE next cycle, no out_valid pulse, and the next block correct.
REQ-034 SHALL cover 1000 random back-to-back blocks with random out_ready: every dout matches the model and no block is lost or duplicated.

Source files
------------

// File: rtl/cipher_pkg.sv
// cipher_pkg: shared FSM state type, row/counter widths and the 4-bit S-box for the round controller.
package cipher_pkg;
   localparam int ROW_W = 16;
   localparam int CNT_W = 6;
   localparam logic [63:0] SBOX = 64'h2174_8FE3_DA09_B65C;
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
   function automatic logic [3:0] sbox(input logic [3:0] x);
      return SBOX[4*x +: 4];
   endfunction
endpackage

// File: rtl/cipher_round_ctrl_if.sv
// cipher_round_ctrl_if: input/output handshake bundle of the cipher round controller.
interface cipher_round_ctrl_if;
   import cipher_pkg::*;
   logic                 in_valid;
   logic                 in_ready;
   logic [4*ROW_W-1:0]   din;
   logic [127:0]         key;
   logic                 out_valid;
   logic                 out_ready;
   logic [4*ROW_W-1:0]   dout;
   logic                 busy;
   modport slave (input in_valid, din, key, out_ready, output in_ready, out_valid, dout, busy);
   modport master (output in_valid, din, key, out_ready, input in_ready, out_valid, dout, busy);
endinterface

// File: rtl/cipher_round.sv
// cipher_round: one combinational round -- nibble S-box layer, round-key mix into rows 0/1, row rotations.
module cipher_round
   import cipher_pkg::*;
(
   input  logic [4*ROW_W-1:0] i_state,
   input  logic [2*ROW_W-1:0] i_rk,
   output logic [4*ROW_W-1:0] o_state
);
   logic [4*ROW_W-1:0] w_sub;
   logic [ROW_W-1:0]   w_r0, w_r1, w_r2, w_r3;
   for (genvar i = 0; i < 4*ROW_W/4; i++) begin : g_sb
      assign w_sub[4*i +: 4] = sbox(i_state[4*i +: 4]);
   end
   assign w_r0 = w_sub[63:48] ^ i_rk[31:16];
   assign w_r1 = w_sub[47:32] ^ i_rk[15:0];
   assign w_r2 = w_sub[31:16];
   assign w_r3 = w_sub[15:0];
   // rows 1..3 rotate left by 1, 8 and 12
   assign o_state = {w_r0, w_r1[14:0], w_r1[15], w_r2[7:0], w_r2[15:8], w_r3[3:0], w_r3[15:4]};
endmodule

// File: rtl/cipher_round_ctrl.sv
// cipher_round_ctrl: iterates cipher_round ROUNDS times per block with a rolling key schedule.
// Optional abort input enabled by CIPHER_ROUND_ABORT_EN.
module cipher_round_ctrl
   import cipher_pkg::*;
#(
   parameter int ROUNDS = 24
)
(
   input  logic clk,
   input  logic rst,
`ifdef CIPHER_ROUND_ABORT_EN
   input  logic abort,
`endif
   cipher_round_ctrl_if.slave bus
);
   state_t             r_st, w_nxt;
   logic [4*ROW_W-1:0] r_state, w_round;
   logic [127:0]       r_key;
   logic [CNT_W-1:0]   r_cnt;
   cipher_round u_round (
      .i_state (r_state),
      .i_rk    (r_key[127:96]),
      .o_state (w_round)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) r_st <= IDLE;
      else     r_st <= w_nxt;
   always_comb begin
      w_nxt = r_st;
      case (r_st)
         IDLE:    w_nxt = bus.in_valid ? LOAD : IDLE;
         LOAD:    w_nxt = RUN;
         RUN:     w_nxt = (r_cnt == CNT_W'(ROUNDS - 1)) ? DONE : RUN;
         DONE:    w_nxt = bus.out_ready ? IDLE : DONE;
         default: w_nxt = IDLE;
      endcase
`ifdef CIPHER_ROUND_ABORT_EN
      if (abort && (r_st == LOAD || r_st == RUN)) w_nxt = IDLE;
`endif
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state <= '0;
         r_key   <= '0;
         r_cnt   <= '0;
      end else if (r_st == IDLE && bus.in_valid) begin
         r_state <= bus.din;
         r_key   <= bus.key;
      end else if (r_st == LOAD) begin
         r_cnt   <= '0;
      end else if (r_st == RUN) begin
         r_state <= w_round;
         r_key   <= {r_key[95:0], r_key[127:96]} ^ {{(128-CNT_W){1'b0}}, r_cnt};
         r_cnt   <= r_cnt + 1'b1;
      end
   assign bus.in_ready  = (r_st == IDLE);
   assign bus.busy      = (r_st == LOAD) || (r_st == RUN);
   assign bus.out_valid = (r_st == DONE);
   assign bus.dout      = (r_st == DONE) ? r_state : '0;
endmodule

// File: tb/tb_cipher_round_ctrl.sv
// tb_cipher_round_ctrl: vector table, corner-case sequences and random traffic against a row/word-level model.
module tb_cipher_round_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   cipher_round_ctrl_if ifa ();
   cipher_round_ctrl_if ifb ();
`ifdef CIPHER_ROUND_ABORT_EN
   logic abort_a = 1'b0;
   logic abort_b = 1'b0;
`endif
   cipher_round_ctrl #(.ROUNDS(24)) dut_a (
      .clk (clk),
      .rst (rst),
`ifdef CIPHER_ROUND_ABORT_EN
      .abort (abort_a),
`endif
      .bus (ifa.slave)
   );
   cipher_round_ctrl #(.ROUNDS(1)) dut_b (
      .clk (clk),
      .rst (rst),
`ifdef CIPHER_ROUND_ABORT_EN
      .abort (abort_b),
`endif
      .bus (ifb.slave)
   );
   int n_cmp = 0;
   int n_err = 0;
   typedef struct {
      logic [63:0]  din;
      logic [127:0] key;
      logic [63:0]  exp;
   } vec_t;
   vec_t vecs [5];
   logic [63:0] q_exp [$];
   function automatic logic [63:0] model(input logic [63:0] d, input logic [127:0] k, input int rounds);
      logic [15:0] row [4];
      logic [31:0] kw [4];
      logic [3:0]  sb [16];
      logic [31:0] rk, t;
      sb = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD, 4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
      for (int i = 0; i < 4; i++) row[i] = d[63-16*i -: 16];
      for (int i = 0; i < 4; i++) kw[i] = k[127-32*i -: 32];
      for (int r = 0; r < rounds; r++) begin
         rk = kw[0];
         for (int i = 0; i < 4; i++)
            for (int n = 0; n < 4; n++) row[i][4*n +: 4] = sb[row[i][4*n +: 4]];
         row[0] = row[0] ^ rk[31:16];
         row[1] = row[1] ^ rk[15:0];
         row[1] = (row[1] << 1) | (row[1] >> 15);
         row[2] = (row[2] << 8) | (row[2] >> 8);
         row[3] = (row[3] << 12) | (row[3] >> 4);
         t = kw[0];
         kw[0] = kw[1];
         kw[1] = kw[2];
         kw[2] = kw[3];
         kw[3] = t ^ 32'(r);
      end
      return {row[0], row[1], row[2], row[3]};
   endfunction
   task automatic chk_bit(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask
   task automatic chk_w(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic run_a(input string name, input logic [63:0] d, input logic [127:0] k, input logic [63:0] exp);
      int lat;
      lat = 0;
      ifa.din = d;
      ifa.key = k;
      ifa.out_ready = 1'b1;
      while (!ifa.in_ready && lat < 100) begin
         tick();
         lat++;
      end
      ifa.in_valid = 1'b1;
      tick();
      ifa.in_valid = 1'b0;
      lat = 1;
      while (!ifa.out_valid && lat < 100) begin
         tick();
         lat++;
      end
      chk_w({name, " latency"}, 64'(lat), 64'd26);
      chk_w({name, " dout"}, ifa.dout, exp);
      tick();
   endtask
   initial begin
      int lat, sent, got, cyc, pulses;
      logic acc;
      logic [63:0] held;
      ifa.in_valid = 1'b0; ifa.din = '0; ifa.key = '0; ifa.out_ready = 1'b1;
      ifb.in_valid = 1'b0; ifb.din = '0; ifb.key = '0; ifb.out_ready = 1'b1;
      vecs[0] = '{64'h0, 128'h0, 64'h0};
      vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 64'h0};
      vecs[2] = '{64'h0123_4567_89AB_CDEF, 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100, 64'h0};
      vecs[3] = '{64'h8000_0000_0000_0001, 128'h0, 64'h0};
      vecs[4] = '{64'hDEAD_BEEF_CAFE_F00D, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 64'h0};
      for (int i = 0; i < 5; i++) vecs[i].exp = model(vecs[i].din, vecs[i].key, 24);
      tick();
      tick();
      chk_bit("reset in_ready", ifa.in_ready, 1'b1);
      chk_bit("reset out_valid", ifa.out_valid, 1'b0);
      chk_bit("reset busy", ifa.busy, 1'b0);
      chk_w("reset dout", ifa.dout, 64'h0);
      rst = 1'b0;
      tick();
      // zero block, cycle-exact busy/out_valid profile
      ifa.din = '0; ifa.key = '0; ifa.out_ready = 1'b1; ifa.in_valid = 1'b1;
      chk_bit("zero in_ready", ifa.in_ready, 1'b1);
      tick();
      ifa.in_valid = 1'b0;
      for (int c = 1; c <= 26; c++) begin
         chk_bit($sformatf("zero busy c%0d", c), ifa.busy, c <= 25);
         chk_bit($sformatf("zero out_valid c%0d", c), ifa.out_valid, c == 26);
         if (c < 26) tick();
      end
      chk_w("zero dout", ifa.dout, model(64'h0, 128'h0, 24));
      tick();
      chk_bit("zero back to idle", ifa.in_ready, 1'b1);
      for (int i = 0; i < 5; i++) run_a($sformatf("vec%0d", i), vecs[i].din, vecs[i].key, vecs[i].exp);
      // back-pressure with a second offer held during DONE
      ifa.din = 64'h1111_2222_3333_4444; ifa.key = 128'h5; ifa.out_ready = 1'b0; ifa.in_valid = 1'b1;
      tick();
      ifa.in_valid = 1'b0;
      lat = 1;
      while (!ifa.out_valid && lat < 100) begin
         tick();
         lat++;
      end
      chk_w("bp latency", 64'(lat), 64'd26);
      held = model(64'h1111_2222_3333_4444, 128'h5, 24);
      ifa.in_valid = 1'b1;
      ifa.din = 64'hAAAA_AAAA_AAAA_AAAA;
      for (int c = 0; c < 10; c++) begin
         chk_w($sformatf("bp dout c%0d", c), ifa.dout, held);
         chk_bit($sformatf("bp in_ready c%0d", c), ifa.in_ready, 1'b0);
         chk_bit($sformatf("bp out_valid c%0d", c), ifa.out_valid, 1'b1);
         tick();
      end
      ifa.in_valid = 1'b0;
      ifa.out_ready = 1'b1;
      tick();
      chk_bit("bp idle in_ready", ifa.in_ready, 1'b1);
      chk_bit("bp idle busy", ifa.busy, 1'b0);
      // reset during RUN round 7 (cycle 9 after acceptance)
      ifa.din = 64'h0F0F_0F0F_F0F0_F0F0; ifa.key = 128'h77; ifa.in_valid = 1'b1;
      tick();
      ifa.in_valid = 1'b0;
      for (int c = 1; c < 9; c++) tick();
      chk_bit("rst mid busy", ifa.busy, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_bit("rst mid in_ready", ifa.in_ready, 1'b1);
      chk_bit("rst mid out_valid", ifa.out_valid, 1'b0);
      chk_w("rst mid dout", ifa.dout, 64'h0);
      run_a("after rst", 64'h0F0F_0F0F_F0F0_F0F0, 128'h77, model(64'h0F0F_0F0F_F0F0_F0F0, 128'h77, 24));
      // single-round instance
      ifb.din = 64'h0123_4567_89AB_CDEF; ifb.key = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100; ifb.in_valid = 1'b1;
      chk_bit("r1 in_ready", ifb.in_ready, 1'b1);
      tick();
      ifb.in_valid = 1'b0;
      lat = 1;
      while (!ifb.out_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk_w("r1 latency", 64'(lat), 64'd3);
      chk_w("r1 dout", ifb.dout, model(64'h0123_4567_89AB_CDEF, 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100, 1));
      tick();
      chk_bit("r1 back to idle", ifb.in_ready, 1'b1);
`ifdef CIPHER_ROUND_ABORT_EN
      ifa.din = 64'h1234; ifa.key = 128'h9; ifa.in_valid = 1'b1;
      tick();
      ifa.in_valid = 1'b0;
      for (int c = 1; c < 5; c++) tick();
      abort_a = 1'b1;
      tick();
      abort_a = 1'b0;
      chk_bit("abort in_ready", ifa.in_ready, 1'b1);
      chk_bit("abort busy", ifa.busy, 1'b0);
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         if (ifa.out_valid) pulses++;
         tick();
      end
      chk_w("abort out_valid pulses", 64'(pulses), 64'd0);
      run_a("after abort", 64'hFEDC_BA98_7654_3210, 128'h3C, model(64'hFEDC_BA98_7654_3210, 128'h3C, 24));
`endif
      // random back-to-back traffic with random consumer stalls
      sent = 0; got = 0; cyc = 0;
      ifa.din = {$urandom, $urandom};
      ifa.key = {$urandom, $urandom, $urandom, $urandom};
      ifa.in_valid = 1'b1;
      while (got < 1000 && cyc < 60000) begin
         ifa.out_ready = 1'($urandom_range(0, 1));
         acc = ifa.in_valid && ifa.in_ready;
         if (acc) begin
            q_exp.push_back(model(ifa.din, ifa.key, 24));
            sent++;
         end
         if (ifa.out_valid && ifa.out_ready) begin
            if (q_exp.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL rand extra block: got %h, expected none", ifa.dout);
            end else begin
               chk_w($sformatf("rand dout %0d", got), ifa.dout, q_exp.pop_front());
            end
            got++;
         end
         tick();
         cyc++;
         if (acc) begin
            ifa.din = {$urandom, $urandom};
            ifa.key = {$urandom, $urandom, $urandom, $urandom};
         end
         ifa.in_valid = sent < 1000;
      end
      chk_w("rand received", 64'(got), 64'd1000);
      chk_w("rand sent", 64'(sent), 64'd1000);
      chk_w("rand leftover", 64'(q_exp.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
